pipeline_stall_ctrl: RTL
========================

// Module: pipeline_stall_ctrl
// PURPOSE
//   Drives the en inputs of the PC and pipeline-stage registers (32-bit load-enable registers)
//   and the bubble/flush controls of the 5-stage MIPS pipeline.
//   Detects load-use hazards, squashes wrong-path instructions on taken branches, and freezes
//   the pipeline while the multicycle MULT/DIV unit is working.
//   It is the control side of every enabled register: those registers load only when this block says so.
// PARAMETERS
//   MULT_CYCLES  4   total freeze cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   32  total freeze cycles for DIV/DIVU (>=1)
//   CNT_W        6   busy-counter width; must hold max(MULT_CYCLES,DIV_CYCLES)-1
// PORTS
//   Clk          in   1  rising-edge clock
//   Rst_n        in   1  asynchronous active-low reset
//   id_rs        in   5  rs field of instruction in ID
//   id_rt        in   5  rt field of instruction in ID
//   id_uses_rt   in   1  ID instruction reads rt as a source
//   ex_rt        in   5  destination rt of instruction in EX
//   ex_mem_read  in   1  EX instruction is a load (LW/LB/...)
//   branch_taken in   1  branch/jump in EX resolved taken this cycle
//   md_start     in   1  MULT/DIV in EX issues this cycle
//   md_is_div    in   1  qualifies md_start: 1=DIV, 0=MULT
//   pc_en        out  1  PC register enable
//   ifid_en      out  1  IF/ID register enable
//   idex_en      out  1  ID/EX register enable
//   exmem_en     out  1  EX/MEM register enable (MEM/WB is never frozen)
//   ifid_flush   out  1  IF/ID loads a NOP this cycle
//   idex_flush   out  1  ID/EX loads a bubble (all control bits 0) this cycle
//   md_busy      out  1  MULT/DIV unit is occupied
//   md_done      out  1  one-cycle pulse on the final busy cycle
// BEHAVIOUR
//   State register: RUN, MD_BUSY. Busy counter cnt[CNT_W-1:0]. Outputs are decoded
//   combinationally from the state and the current inputs.
//   While Rst_n=0 (asynchronous): state=RUN, cnt=0. All en, flush, md_busy and md_done are 0.
//   First rising edge after release: RUN outputs are active.
//   RUN, evaluated in priority order:
//     1 branch_taken=1: pc_en=ifid_en=idex_en=exmem_en=1; ifid_flush=idex_flush=1.
//       md_start and the load-use check are ignored.
//     2 md_start=1: all en=1 on this cycle, so the MULT/DIV result path advances into EX/MEM.
//       Next state is MD_BUSY, with cnt <= (md_is_div ? DIV_CYCLES : MULT_CYCLES)-1.
//     3 load-use hazard, defined as ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)):
//       pc_en=ifid_en=0; idex_en=exmem_en=1; idex_flush=1; ifid_flush=0.
//       Exactly one stall cycle: the bubble clears ex_mem_read on the next cycle.
//     4 otherwise: all en=1, both flush=0.
//   MD_BUSY:
//     pc_en=ifid_en=idex_en=exmem_en=0; flush=0; md_busy=1.
//     branch_taken, md_start and the hazard inputs are ignored; they are stale because the
//     stages are frozen.
//     cnt!=0: cnt decrements each cycle.
//     cnt==0: md_done=1 this cycle; next state is RUN.
//   Busy length: exactly N cycles with md_busy=1 after the issue cycle (N = MULT_CYCLES or DIV_CYCLES).
//   md_done coincides with the last of those cycles.
//   A new md_start on the first RUN cycle after MD_BUSY is accepted, with no dead cycle.
//   Reset asserted mid-MD_BUSY aborts immediately: no md_done pulse. After release the state is RUN.
//   Register 0 is never a hazard source. Hazard detection is combinational with zero latency.
//   Outputs must be glitch-tolerant. They feed only synchronous enables.
// TESTING
//   1 Reset: hold Rst_n=0 with random inputs -> all outputs 0. Release -> cycle 1: pc_en=ifid_en=idex_en=exmem_en=1.
//   2 Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1.
//     Same stimulus with ex_rt=0, or id_rt=5 with id_uses_rt=0 -> no stall.
//   3 Branch priority: branch_taken=1 together with the load-use hazard of test 2 -> ifid_flush=idex_flush=1, pc_en=1, no stall.
//   4 MULT: md_start=1, md_is_div=0 -> md_busy=1 for exactly 4 cycles, all en=0, md_done high on the 4th only.
//     Next cycle: all en=1.
//   5 DIV back-to-back: md_start with md_is_div=1 -> 32 busy cycles.
//     Second md_start on the first RUN cycle -> busy again immediately. branch_taken pulsed mid-busy -> no flush.
//   6 Reset mid-DIV: drop Rst_n at busy cycle 10 -> outputs 0 asynchronously, no md_done.
//     After release: RUN with md_busy=0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Stall, flush and freeze control for the 5-stage pipeline.
// Handles load-use hazards, taken-branch squashes and multicycle MULT/DIV freezes.
module pipeline_stall_ctrl #(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic [4:0] ex_rt,
   input  logic       ex_mem_read,
   input  logic       branch_taken,
   input  logic       md_start,
   input  logic       md_is_div,
   output logic       pc_en,
   output logic       ifid_en,
   output logic       idex_en,
   output logic       exmem_en,
   output logic       ifid_flush,
   output logic       idex_flush,
   output logic       md_busy,
   output logic       md_done
);

   typedef enum logic {RUN, MD_BUSY} state_e;

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             live_q, live_d;
   logic             hazard;

   assign hazard = ex_mem_read & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

   // live_q keeps every enable low until the first edge after reset release
   assign live_d = 1'b1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      md_busy    = 1'b0;
      md_done    = 1'b0;
      unique case (state_q)
         RUN: begin
            if (live_q) begin
               idex_en  = 1'b1;
               exmem_en = 1'b1;
               if (branch_taken) begin
                  pc_en      = 1'b1;
                  ifid_en    = 1'b1;
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (md_start) begin
                  pc_en   = 1'b1;
                  ifid_en = 1'b1;
                  state_d = MD_BUSY;
                  cnt_d   = md_is_div ? DIV_LD : MULT_LD;
               end else if (hazard) begin
                  idex_flush = 1'b1;
               end else begin
                  pc_en   = 1'b1;
                  ifid_en = 1'b1;
               end
            end
         end
         MD_BUSY: begin
            md_busy = 1'b1;
            if (cnt_q == '0) begin
               md_done = 1'b1;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         live_q  <= live_d;
      end
   end

endmodule
